// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C memory target.
//   i2c_slv_st_t : protocol FSM state
//   SYNC_LEN     : depth of the input synchronizer
//   i2c_byte_t   : one bus / memory byte
package i2c_slv_pkg;

    localparam int unsigned SYNC_LEN = 2;

    typedef logic [7:0] i2c_byte_t;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } i2c_slv_st_t;

endpackage

// File: rtl/i2c_in_filt.sv
// Input conditioning for one raw I2C line: SYNC_LEN-flop synchronizer followed by a
// glitch filter that only accepts a new level after FILT_LEN consecutive equal samples.
// Input-to-output latency is SYNC_LEN + FILT_LEN cycles.
//   clk     : system clock
//   resetn  : asynchronous active-low reset (line idles high)
//   i_line  : raw line level
//   o_level : registered filtered level
module i2c_in_filt
    import i2c_slv_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_line,
    output logic o_level
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [SYNC_LEN-1:0] r_sync;
    logic [CW-1:0]       r_cnt;
    logic                r_level;
    logic                w_sync;

    assign w_sync  = r_sync[SYNC_LEN-1];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_LEN-2:0], i_line};
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                // FILT_LEN-th consecutive differing sample: accept the new level
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_mem_slv.sv
// I2C target with an internal byte memory: 7-bit addressing, 8-bit register pointer with
// auto-increment, byte/burst write, random and sequential read. SCL is never driven.
//   clk     : system clock (>= 16x SCL)
//   resetn  : asynchronous active-low reset
//   scl_i   : raw SCL level
//   sda_i   : raw SDA level
//   sda_oe  : 1 = pull SDA low, 0 = release
//   busy    : addressed transfer in progress (matched START .. STOP)
//   wr_stb  : one-cycle pulse per memory byte written, with wr_addr / wr_data
//   rd_stb  : one-cycle pulse when a read byte is loaded for transmission
module i2c_mem_slv
    import i2c_slv_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR  = 7'h50,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned FILT_LEN  = 3,
    parameter logic [7:0]  INIT_VAL  = 8'h00
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      scl_i,
    input  logic      sda_i,
    output logic      sda_oe,
    output logic      busy,
    output logic      wr_stb,
    output i2c_byte_t wr_addr,
    output i2c_byte_t wr_data,
    output logic      rd_stb
);

    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam i2c_byte_t   PTR_MASK = i2c_byte_t'(MEM_DEPTH - 1);

    logic        w_scl, w_sda;
    logic        r_scl_prev, r_sda_prev;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_slv_st_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    i2c_byte_t   r_shift, w_shift_nxt;
    i2c_byte_t   r_ptr, w_ptr_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_wr_stb, w_wr_stb_nxt;
    logic        r_rd_stb, w_rd_stb_nxt;
    i2c_byte_t   r_wr_addr, w_wr_addr_nxt;
    i2c_byte_t   r_wr_data, w_wr_data_nxt;
    logic        w_mem_we;
    i2c_byte_t   r_mem [MEM_DEPTH];

    i2c_byte_t   w_rx_byte, w_rd_byte, w_ptr_inc;
    logic        w_addr_hit;

    i2c_in_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .resetn (resetn),
        .i_line (scl_i),
        .o_level(w_scl)
    );

    i2c_in_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .resetn (resetn),
        .i_line (sda_i),
        .o_level(w_sda)
    );

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // SCL must have been high on both samples so an SCL edge is never mistaken for a condition
    assign w_start    = r_sda_prev & ~w_sda & w_scl & r_scl_prev;
    assign w_stop     = ~r_sda_prev & w_sda & w_scl & r_scl_prev;

    assign w_rx_byte  = {r_shift[6:0], w_sda};
    assign w_rd_byte  = r_mem[r_ptr[AW-1:0]];
    assign w_ptr_inc  = (r_ptr + 8'd1) & PTR_MASK;
    // r_shift[6:0] holds the 7 address bits when the R/W bit arrives; general call never matches
    assign w_addr_hit = (r_shift[6:0] == SLV_ADDR) && (SLV_ADDR != 7'h00);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_oe_nxt      = r_oe;
        w_busy_nxt    = r_busy;
        w_wr_stb_nxt  = 1'b0;
        w_rd_stb_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_mem_we      = 1'b0;

        if (w_stop) begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
        end else if (w_start) begin
            // busy is re-decided by the address that follows
            w_state_nxt = StAddr;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                StAddr: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt = '0;
                            if (w_addr_hit) begin
                                w_state_nxt = StAddrAck;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_sda;
                            end else begin
                                w_state_nxt = StIgnore;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                // ACK states: r_cnt==0 waits for the fall after bit 8 to pull low,
                // r_cnt==1 waits for the fall that ends the ACK clock
                StAddrAck: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_oe_nxt  = 1'b1;
                            w_cnt_nxt = 4'd1;
                        end else if (r_rw) begin
                            w_state_nxt  = StRdata;
                            w_shift_nxt  = w_rd_byte;
                            w_oe_nxt     = ~w_rd_byte[7];
                            w_rd_stb_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt = StPtr;
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                StPtr: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_ptr_nxt   = w_rx_byte & PTR_MASK;
                            w_state_nxt = StPtrAck;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_oe_nxt  = 1'b1;
                            w_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt = StWdata;
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                StWdata: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_mem_we      = 1'b1;
                            w_wr_stb_nxt  = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = w_rx_byte;
                            w_ptr_nxt     = w_ptr_inc;
                            w_state_nxt   = StWdataAck;
                            w_cnt_nxt     = '0;
                        end
                    end
                end
                StRdata: begin
                    // r_cnt counts SCL rises; each fall presents the next bit
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_nxt = StRdataAck;
                            w_oe_nxt    = 1'b0;
                            w_ptr_nxt   = w_ptr_inc;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_oe_nxt    = ~r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                StRdataAck: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[7:1], w_sda};
                        w_cnt_nxt   = 4'd1;
                    end else if (w_scl_fall && (r_cnt == 4'd1)) begin
                        if (!r_shift[0]) begin
                            w_state_nxt  = StRdata;
                            w_shift_nxt  = w_rd_byte;
                            w_oe_nxt     = ~w_rd_byte[7];
                            w_rd_stb_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt = StIgnore;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                StIgnore: begin
                    w_oe_nxt = 1'b0;
                end
                StIdle: begin
                    w_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                r_mem[i] <= INIT_VAL;
            end
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rw       <= w_rw_nxt;
            r_oe       <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_stb   <= w_wr_stb_nxt;
            r_rd_stb   <= w_rd_stb_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            if (w_mem_we) begin
                r_mem[r_ptr[AW-1:0]] <= w_rx_byte;
            end
        end
    end

    assign sda_oe  = r_oe;
    assign busy    = r_busy;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_stb  = r_rd_stb;

endmodule

// File: doc/i2c_mem_slv.md
Name: i2c_mem_slv

Overview:
- Synthesizable I2C target (slave) with an internal byte memory.
- Sits directly downstream of the Lattice I2C controller on the SCL/SDA bus.
- RTL counterpart of the behavioural i2c_mem model, so the same i2c tests run against the controller with a real target on the bus, in simulation and on the board.
- Protocol: 7-bit addressing, 8-bit register pointer with auto-increment, byte write, random read, sequential read.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address this block responds to.
- MEM_DEPTH, 256, number of bytes of internal memory; power of two, 2..256.
- FILT_LEN, 3, consecutive equal samples required to accept a new filtered SCL/SDA level.
- INIT_VAL, 8'h00, value loaded into every memory byte at reset.

Ports:
- clk  in  1  system clock; at least 16x SCL frequency.
- resetn  in  1  asynchronous, active-low reset.
- scl_i  in  1  raw SCL line level.
- sda_i  in  1  raw SDA line level.
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release the line.
- busy  out  1  high from a START addressed to SLV_ADDR until STOP.
- wr_stb  out  1  one-cycle pulse per memory byte written.
- wr_addr  out  8  memory address of the write, valid with wr_stb.
- wr_data  out  8  data byte written, valid with wr_stb.
- rd_stb  out  1  one-cycle pulse when a read byte is loaded for transmission.

Behaviour:

Input conditioning:
- scl_i and sda_i each pass through a 2-flop synchronizer, then a FILT_LEN-sample glitch filter.
- Edge and condition detection uses the filtered levels only.
- Input-to-filtered latency is 2+FILT_LEN cycles.

Bus conditions:
- START: filtered SDA falls while filtered SCL is high.
- STOP: filtered SDA rises while filtered SCL is high.
- Data bits are sampled on the filtered SCL rising edge, MSB first.

Output timing:
- sda_oe changes only in the cycle after a filtered SCL falling edge.
- sda_oe is held until the next filtered SCL falling edge.

Reset (resetn low, asynchronous):
- sda_oe=0, busy=0, wr_stb=0, rd_stb=0, wr_addr=0, wr_data=0.
- FSM goes to IDLE, pointer=0, every memory byte = INIT_VAL.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: START -> ADDR.
- ADDR: shift 8 bits (7-bit address + R/W).
  - Address match -> ADDR_ACK and busy=1.
  - Mismatch -> IGNORE.
- ADDR_ACK: drive the ACK bit low.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA: load mem[pointer] into the shift register and pulse rd_stb.
- PTR: receive 8 bits.
  - pointer = byte mod MEM_DEPTH.
  - Then PTR_ACK (ACK) -> WDATA.
- WDATA: receive 8 bits.
  - Write mem[pointer] and pulse wr_stb with wr_addr=pointer, wr_data=byte, on the 8th SCL rising edge.
  - Then WDATA_ACK (ACK), pointer+1 wrapping at MEM_DEPTH, -> WDATA.
- RDATA: drive 8 bits.
  - sda_oe = ~bit, so a 0 bit pulls low and a 1 bit releases.
  - Then RDATA_ACK: release SDA and sample the controller's ACK; pointer+1 wraps.
  - ACK (0) -> load the next byte, pulse rd_stb, -> RDATA.
  - NACK (1) -> IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.

Condition handling:
- STOP in any state -> IDLE: busy=0, sda_oe=0.
- START (repeated) in any state -> ADDR: busy stays 1 only if the new address matches; the pointer is kept.
- Neither condition is treated as a data bit.
- STOP before the 8th PTR bit leaves the pointer unchanged.
- A write of fewer than 8 data bits is discarded; no wr_stb.

Simultaneous events and other rules:
- A START/STOP detected in the same cycle as an SCL edge takes priority.
- An address match is exactly 7 bits; general call (7'h00) is not acknowledged.
- No clock stretching: SCL is never driven.
- Reset mid-transfer releases SDA immediately, since the reset is asynchronous.

Decomposition:
- Package i2c_slv_pkg holds:
  - typedef enum logic [3:0] i2c_slv_st_t with the states above;
  - localparam SYNC_LEN = 2;
  - typedef logic [7:0] i2c_byte_t.
- One sub-module, i2c_in_filt: 2-flop synchronizer plus FILT_LEN filter for a single line, with registered output level. It is instantiated twice (SCL, SDA).
- FSM, shift register, bit counter, pointer and memory stay in i2c_mem_slv.

Test Plan:
- Reset, then idle bus -> sda_oe=0, busy=0; a read of pointer 8'h00 returns 8'h00 (INIT_VAL).
- Write 0xA0, ptr 0x10, data 0x11,0x22,0x33, STOP -> 3 ACKs after the data, plus ACKs for address and pointer; wr_stb x3 with wr_addr 0x10/0x11/0x12, wr_data 0x11/0x22/0x33; busy drops after STOP.
- Random read: 0xA0, ptr 0x11, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> data 0x22, 0x33; two rd_stb pulses; SDA released at NACK.
- Address 0xA2 (7'h51) -> SDA never driven low, busy stays 0, no wr_stb; the next transfer to 0xA0 works.
- Wrap-around: ptr 0xFF, write 0xAB,0xCD -> mem[0xFF]=0xAB, mem[0x00]=0xCD; a sequential read from 0xFF returns 0xAB, 0xCD.
- Glitch and reset: SCL pulse of FILT_LEN-1 cycles mid-byte -> no bit counted; resetn low during RDATA with sda_oe=1 -> sda_oe=0 in the same cycle, FSM returns to IDLE.
